// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a circular return-address stack.
// Two states (RUN / HALTED). Redirect priority in RUN is ret > call > jump > branch > increment.
// Every output comes straight from registered state.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter int               RAS_DEPTH    = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STEP         = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             halt,
  input  logic                             resume,
  input  logic                             stall,
  input  logic                             branch,
  input  logic                             jump,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             relative,
  input  logic [WIDTH-1:0]                 immediate,
  output logic [WIDTH-1:0]                 programCounter,
  output logic                             halted,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   rasDepth,
  output logic                             rasEmpty,
  output logic                             rasFull,
  output logic                             rasError
);

  localparam int PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int DEPTH_W = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0]   STEP_V = WIDTH'(STEP);
  localparam logic [DEPTH_W-1:0] FULL_V = DEPTH_W'(RAS_DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;      // next slot to write; top of stack is ptr_q-1
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic               push_en;
  logic [WIDTH-1:0]   seq_pc, target, top;
  logic [WIDTH-1:0]   stack [RAS_DEPTH];

  assign seq_pc = pc_q + STEP_V;
  assign target = relative ? (pc_q + immediate) : immediate;
  assign top    = stack[ptr_q - PTR_W'(1)];

  // Next-state and sequencing decisions; defaults hold everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    err_d   = err_q;
    push_en = 1'b0;
    case (state_q)
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else if (!stall) begin
          if (ret) begin
            if (depth_q == '0) begin
              // Underflow: fall through sequentially, stack untouched.
              pc_d  = seq_pc;
              err_d = 1'b1;
            end else begin
              pc_d    = top;
              ptr_d   = ptr_q - PTR_W'(1);
              depth_d = depth_q - DEPTH_W'(1);
            end
          end else if (call) begin
            // Push always happens; when full the pointer wrap overwrites the oldest entry.
            pc_d    = target;
            push_en = 1'b1;
            ptr_d   = ptr_q + PTR_W'(1);
            if (depth_q == FULL_V) err_d = 1'b1;
            else                   depth_d = depth_q + DEPTH_W'(1);
          end else if (jump || branch) begin
            pc_d = target;
          end else begin
            pc_d = seq_pc;
          end
        end
      end
      HALTED: begin
        if (resume && !halt) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Control state: FSM, PC, stack pointer, depth and sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      ptr_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Return-address storage; contents need no reset since depth gates reachability.
  always_ff @(posedge clock) begin
    if (push_en) stack[ptr_q] <= seq_pc;
  end

  assign programCounter = pc_q;
  assign halted         = (state_q == HALTED);
  assign rasDepth       = depth_q;
  assign rasEmpty       = (depth_q == '0);
  assign rasFull        = (depth_q == FULL_V);
  assign rasError       = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of pc_sequencer with hand-computed expectations.
// A second, 8-bit instance shares the controls and covers PC wrap.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        halt, resume, stall, branch, jump, call, ret, relative;
  logic [31:0] immediate;
  logic [31:0] pc;
  logic        halted, ras_empty, ras_full, ras_error;
  logic [3:0]  ras_depth;
  logic [7:0]  pc8;
  logic        halted8, empty8, full8, error8;
  logic [3:0]  depth8;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.WIDTH(32), .RAS_DEPTH(8)) u_dut (
    .clock(clock), .reset(reset), .halt(halt), .resume(resume), .stall(stall),
    .branch(branch), .jump(jump), .call(call), .ret(ret), .relative(relative),
    .immediate(immediate), .programCounter(pc), .halted(halted), .rasDepth(ras_depth),
    .rasEmpty(ras_empty), .rasFull(ras_full), .rasError(ras_error)
  );

  pc_sequencer #(.WIDTH(8), .RAS_DEPTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .halt(halt), .resume(resume), .stall(stall),
    .branch(branch), .jump(jump), .call(call), .ret(ret), .relative(relative),
    .immediate(immediate[7:0]), .programCounter(pc8), .halted(halted8), .rasDepth(depth8),
    .rasEmpty(empty8), .rasFull(full8), .rasError(error8)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    halt = 0; resume = 0; stall = 0; branch = 0; jump = 0;
    call = 0; ret = 0; relative = 0; immediate = '0;
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_jump(input logic [31:0] addr);
    idle(); jump = 1; immediate = addr; step(); idle();
  endtask

  task automatic do_call(input logic [31:0] addr);
    idle(); call = 1; immediate = addr; step(); idle();
  endtask

  task automatic do_ret();
    idle(); ret = 1; step(); idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #2;
    chk("rst_pc",    pc,        32'd0);
    chk("rst_halt",  halted,    1'b0);
    chk("rst_depth", ras_depth, 4'd0);
    chk("rst_empty", ras_empty, 1'b1);
    chk("rst_full",  ras_full,  1'b0);
    chk("rst_err",   ras_error, 1'b0);
    chk("rst_pc8",   pc8,       8'd0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    #1 chk("rel_pc", pc, 32'd0);

    // Free-running increment
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("inc_pc%0d", i), pc, 32'(i));
    end
    chk("inc_halt", halted, 1'b0);

    // Branch relative with negative offset, then absolute jump
    do_jump(32'd10);
    chk("jmp10", pc, 32'd10);
    branch = 1; relative = 1; immediate = 32'hFFFF_FFFC; step(); idle();
    chk("br_rel", pc, 32'd6);
    do_jump(32'h100);
    chk("jmp_abs", pc, 32'h100);

    // Nested call / return
    do_jump(32'h20);
    do_call(32'h80);
    chk("call1_pc", pc, 32'h80);  chk("call1_d", ras_depth, 4'd1);
    do_call(32'hC0);
    chk("call2_pc", pc, 32'hC0);  chk("call2_d", ras_depth, 4'd2);
    do_ret();
    chk("ret1_pc", pc, 32'h81);   chk("ret1_d", ras_depth, 4'd1);
    do_ret();
    chk("ret2_pc", pc, 32'h21);   chk("ret2_d", ras_depth, 4'd0);
    chk("ret_err", ras_error, 1'b0);

    // Stall freezes PC even with a jump pending
    stall = 1; jump = 1; immediate = 32'h300; step(); idle();
    chk("stall_pc", pc, 32'h21);

    // Overflow: 9 calls from 0x21, targets 0x100,0x110,...,0x180
    for (int i = 0; i < 9; i++) do_call(32'h100 + 32'(i) * 32'h10);
    chk("ovf_pc",    pc,        32'h180);
    chk("ovf_depth", ras_depth, 4'd8);
    chk("ovf_full",  ras_full,  1'b1);
    chk("ovf_err",   ras_error, 1'b1);
    // Newest 8 return addresses: 0x171 down to 0x101; 0x22 was overwritten
    for (int i = 7; i >= 0; i--) begin
      do_ret();
      chk($sformatf("pop_pc%0d", i), pc, 32'h101 + 32'(i) * 32'h10);
    end
    chk("pop_empty", ras_empty, 1'b1);
    do_ret();
    chk("unf_pc",    pc,        32'h102);
    chk("unf_empty", ras_empty, 1'b1);
    chk("unf_err",   ras_error, 1'b1);
    // call+ret together: ret wins, no push
    call = 1; ret = 1; immediate = 32'h500; step(); idle();
    chk("cr_pc", pc, 32'h103);
    chk("cr_d",  ras_depth, 4'd0);

    // Halt with a jump held on
    do_jump(32'd5);
    halt = 1; jump = 1; immediate = 32'h40; step();
    chk("halt_pc0", pc, 32'd5); chk("halt_h0", halted, 1'b1);
    halt = 0;
    for (int i = 1; i <= 2; i++) begin
      step();
      chk($sformatf("halt_pc%0d", i), pc, 32'd5);
      chk($sformatf("halt_h%0d", i), halted, 1'b1);
    end
    idle(); resume = 1; step(); idle();
    chk("res_pc", pc, 32'd5); chk("res_h", halted, 1'b0);
    step();
    chk("res_inc", pc, 32'd6);
    halt = 1; step(); idle();
    chk("h2_h", halted, 1'b1);
    halt = 1; resume = 1; step(); idle();
    chk("hr_h", halted, 1'b1); chk("hr_pc", pc, 32'd6);

    // Asynchronous reset while halted with three stacked entries
    resume = 1; step(); idle();
    do_call(32'h200); do_call(32'h210); do_call(32'h220);
    halt = 1; step(); idle();
    chk("pre_d", ras_depth, 4'd3); chk("pre_h", halted, 1'b1);
    #3 reset = 1'b0;
    #1;
    chk("ar_pc", pc, 32'd0);   chk("ar_h", halted, 1'b0);
    chk("ar_d", ras_depth, 4'd0); chk("ar_empty", ras_empty, 1'b1);
    chk("ar_err", ras_error, 1'b0);
    #1 reset = 1'b1;
    step();
    chk("post_pc", pc, 32'd1);

    // 8-bit wrap
    do_jump(32'hFF);
    chk("w8_ff", pc8, 8'hFF);
    step();
    chk("w8_wrap", pc8, 8'h00);
    chk("w32_nowrap", pc, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, PC/immediate width in bits (>= 4).
REQ-002 Parameter: RAS_DEPTH, 8, return-address-stack entries (>= 2, power of two).
REQ-003 Parameter: RESET_VECTOR, 0, PC value loaded on reset.
REQ-004 Parameter: STEP, 1, sequential increment added to PC.
REQ-005 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-low reset.
REQ-007 Port: halt  input  1  request entry to HALTED.
REQ-008 Port: resume  input  1  request return from HALTED to RUN.
REQ-009 Port: stall  input  1  freeze PC and stack for this cycle.
REQ-010 Port: branch  input  1  conditional redirect taken.
REQ-011 Port: jump  input  1  unconditional redirect.
REQ-012 Port: call  input  1  redirect and push PC+STEP.
REQ-013 Port: ret  input  1  redirect to popped return address.
REQ-014 Port: relative  input  1  1: target = PC+immediate; 0: target = immediate.
REQ-015 Port: immediate  input  WIDTH  redirect offset/address.
REQ-016 Port: programCounter  output  WIDTH  current PC.
REQ-017 Port: halted  output  1  1 while in HALTED.
REQ-018 Port: rasDepth  output  clog2(RAS_DEPTH+1)  valid stack entries.
REQ-019 Port: rasEmpty / rasFull  output  1 each  rasDepth==0 / rasDepth==RAS_DEPTH.
REQ-020 Port: rasError  output  1  sticky: underflow or overflow occurred.

Function
REQ-021 States RUN and HALTED; encoding free; only these two reachable.
REQ-022 RUN with halt=1: next state HALTED; PC, stack unchanged that edge; other controls ignored.
REQ-023 HALTED: PC and stack hold; all controls except resume ignored; halt=1 and resume=1 together keeps HALTED.
REQ-024 HALTED with resume=1, halt=0: next state RUN, PC unchanged; normal sequencing from following edge.
REQ-025 RUN, halt=0, stall=1: PC, stack, rasError hold.
REQ-026 RUN, halt=0, stall=0, priority ret > call > jump > branch > increment; lower-priority requests that cycle are dropped.
REQ-027 target = relative ? (PC + immediate) mod 2^WIDTH : immediate; applies to call, jump, branch.
REQ-028 jump or branch: PC <= target.
REQ-029 call: PC <= target; push (PC+STEP) mod 2^WIDTH; rasDepth+1.
REQ-030 call with rasFull: push still performed, oldest entry overwritten (circular), rasDepth stays RAS_DEPTH, rasError <= 1.
REQ-031 ret with rasEmpty=0: PC <= top entry; rasDepth-1.
REQ-032 ret with rasEmpty=1: PC <= PC+STEP, stack unchanged, rasError <= 1.
REQ-033 No request: PC <= (PC+STEP) mod 2^WIDTH; wraps at 2^WIDTH silently.
REQ-034 call+ret same cycle: ret only (REQ-026); no push.
REQ-035 All outputs registered or derived combinationally from registered state; zero input-to-output combinational paths.
REQ-036 Redirect latency: new PC visible on programCounter after exactly one rising edge.

Reset
REQ-037 reset=0 asynchronously forces: PC=RESET_VECTOR, state RUN, halted=0, rasDepth=0, rasEmpty=1, rasFull=0, rasError=0.
REQ-038 Reset mid-halt or mid-stack-use discards all state; stack contents need not be cleared but are unreachable.
REQ-039 First active edge after reset release performs normal RUN sequencing.
REQ-040 rasError clears only on reset.

Verification
REQ-041 Reset release, no controls, 4 edges -> PC 0,1,2,3,4; halted=0.
REQ-042 PC=10, relative=1, immediate=-4 (two's complement), branch=1 -> PC=6; relative=0, jump=1, immediate=0x100 -> PC=0x100.
REQ-043 PC=0x20 call target 0x80; at 0x80 call target 0xC0; ret; ret -> PC 0x80, 0xC0, 0x81, 0x21; rasDepth 1,2,1,0; rasError=0.
REQ-044 RAS_DEPTH=8: 9 nested calls -> rasFull=1, rasError=1, rasDepth=8; 8 rets return newest 8 addresses; 9th ret -> PC+1, rasEmpty=1.
REQ-045 halt at PC=5 -> PC stays 5, halted=1 for 3 edges with jump=1 asserted; resume -> PC 5 then 6; halt+resume together in HALTED -> stays halted.
REQ-046 Assert reset=0 between edges while halted with rasDepth=3 -> immediately PC=RESET_VECTOR, halted=0, rasDepth=0; WIDTH=8 wrap check: PC=0xFF increments to 0x00.
